byte_serial_adder32: RTL and testbench

- Byte-serial modular 2^32 adder for the 8-bit SEED datapath. It is the carry-propagating counterpart of the datapath's borrow-chained byte subtractor.
- Two 32-bit operands arrive one byte per beat, LSB first, with a valid/ready handshake. It produces the sum byte-serially with a one-beat registered latency.
- Feeds the F-function and key-schedule mod-2^32 additions.

---
 rtl/byte_serial_adder32_pkg.sv | 16 +
 rtl/byte_serial_adder32_if.sv | 25 ++
 rtl/byte_serial_adder32_byte_adder.sv | 13 +
 rtl/byte_serial_adder32.sv | 94 +++++++++
 tb/tb_byte_serial_adder32.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/byte_serial_adder32_pkg.sv
// Shared constants and types for the 8-bit SEED datapath byte-serial blocks.
package seed_pkg;

  localparam int WORD_BYTES_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Byte counter width; never narrower than one bit so single-byte words still compile.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/byte_serial_adder32_if.sv
// Byte-stream handshake between an operand source, the adder and the sum sink.
interface byte_serial_adder32_if;
  logic       start;
  logic       in_valid;
  logic [7:0] a_in;
  logic [7:0] b_in;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum_out;
  logic       out_last;
  logic       carry_out;

  // Source/sink side: drives operands and accepts sums.
  modport master (
    output start, in_valid, a_in, b_in, out_ready,
    input  in_ready, out_valid, sum_out, out_last, carry_out
  );

  // Adder side.
  modport slave (
    input  start, in_valid, a_in, b_in, out_ready,
    output in_ready, out_valid, sum_out, out_last, carry_out
  );
endinterface

// File: rtl/byte_serial_adder32_byte_adder.sv
// One-byte ripple adder stage; the add-direction twin of the byte subtractor.
module byte_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c_in,
  output logic [7:0] sum,
  output logic       c_out
);

  // 9-bit add keeps the carry as the top bit.
  assign {c_out, sum} = {1'b0, a} + {1'b0, b} + {8'd0, c_in};

endmodule

// File: rtl/byte_serial_adder32.sv
// Byte-serial mod-2^32 adder: operands LSB first, one registered sum byte per beat.
module byte_serial_adder32
  import seed_pkg::*;
#(
  parameter int WORD_BYTES = WORD_BYTES_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  byte_serial_adder32_if.slave bus,
  output logic                 busy
);

  localparam int             CW       = cnt_width(WORD_BYTES);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WORD_BYTES - 1);

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic            carry_q;
  logic            out_valid_q;
  logic [7:0]      sum_q;
  logic            last_q;
  logic            cout_q;

  logic            in_ready;
  logic            accept;
  logic            take;
  logic [CW-1:0]   idx;
  logic            cin;
  logic            is_last;
  logic [7:0]      add_sum;
  logic            add_cout;

  // Single output register: free to load when empty or being drained this cycle.
  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready;
  // A byte without start while idle belongs to no word and is dropped.
  assign take     = accept && (bus.start || state_q == RUN);

  // start always restarts the word, so byte 0 never sees a stale carry.
  assign idx      = bus.start ? '0 : cnt_q;
  assign cin      = bus.start ? 1'b0 : carry_q;
  assign is_last  = (idx == LAST_IDX);

  byte_adder u_add (
    .a     (bus.a_in),
    .b     (bus.b_in),
    .c_in  (cin),
    .sum   (add_sum),
    .c_out (add_cout)
  );

  // Word sequencing, carry chain and the registered output beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      sum_q       <= 8'h00;
      last_q      <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      if (in_ready) begin
        out_valid_q <= take;
        if (take) begin
          sum_q  <= add_sum;
          last_q <= is_last;
          cout_q <= is_last & add_cout;
        end else begin
          last_q <= 1'b0;
          cout_q <= 1'b0;
        end
      end
      if (take) begin
        carry_q <= add_cout;
        if (is_last) begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= RUN;
          cnt_q   <= idx + CW'(1);
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.sum_out   = sum_q;
  assign bus.out_last  = last_q;
  assign bus.carry_out = cout_q;
  assign busy          = (state_q == RUN);

endmodule

// File: tb/tb_byte_serial_adder32.sv
// Scoreboard bench for byte_serial_adder32: word-level expected sums, byte-level compare.
module tb_byte_serial_adder32;

  typedef struct packed {
    logic [7:0] sum;
    logic       last;
    logic       carry;
  } exp_t;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_vec;
  int   n_err;
  exp_t exp_q[$];

  byte_serial_adder32_if bus ();

  byte_serial_adder32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one byte, optionally queue its expected output, wait until accepted.
  task automatic send_byte(input logic [7:0] a, input logic [7:0] b, input logic st,
                           input logic psh, input exp_t e);
    int n;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.start    = st;
    bus.in_valid = 1'b1;
    if (psh) exp_q.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_ready && n < 200);
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  function automatic exp_t exp_byte(input logic [31:0] a, input logic [31:0] b, input int i);
    logic [32:0] s;
    exp_t e;
    s       = {1'b0, a} + {1'b0, b};
    e.sum   = s[8*i +: 8];
    e.last  = (i == 3);
    e.carry = (i == 3) ? s[32] : 1'b0;
    return e;
  endfunction

  // First nb bytes of a word; fewer than 4 leaves it unfinished.
  task automatic send_word(input logic [31:0] a, input logic [31:0] b, input int nb);
    for (int i = 0; i < nb; i++)
      send_byte(a[8*i +: 8], b[8*i +: 8], (i == 0), 1'b1, exp_byte(a, b, i));
  endtask

  // Compare every byte the sink actually takes against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", {24'd0, bus.sum_out}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum_out",   {24'd0, bus.sum_out},   {24'd0, e.sum});
        chk("out_last",  {31'd0, bus.out_last},  {31'd0, e.last});
        chk("carry_out", {31'd0, bus.carry_out}, {31'd0, e.carry});
      end
    end
  end

  initial begin
    logic [31:0] wa;
    logic [31:0] wb;
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_in     = 8'h00;
    bus.b_in     = 8'h00;
    bus.out_ready = 1'b1;

    #3;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_sum_out",   {24'd0, bus.sum_out},   32'd0);
    chk("rst_out_last",  {31'd0, bus.out_last},  32'd0);
    chk("rst_carry_out", {31'd0, bus.carry_out}, 32'd0);
    chk("rst_busy",      {31'd0, busy},          32'd0);
    chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic add, full overflow, then carry isolation back-to-back.
    send_word(32'h9E3779B9, 32'h12345678, 4);
    send_word(32'hFFFFFFFF, 32'h00000001, 4);
    send_word(32'h00000000, 32'h00000000, 4);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure after byte 1.
    wa = 32'h9E3779B9;
    wb = 32'h12345678;
    send_byte(wa[7:0],  wb[7:0],  1'b1, 1'b1, exp_byte(wa, wb, 0));
    send_byte(wa[15:8], wb[15:8], 1'b0, 1'b1, exp_byte(wa, wb, 1));
    bus.out_ready = 1'b0;
    fork
      send_byte(wa[23:16], wb[23:16], 1'b0, 1'b1, exp_byte(wa, wb, 2));
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_sum",  {24'd0, bus.sum_out},   32'hD0);
          chk("bp_in_ready",  {31'd0, bus.in_ready},  32'd0);
          chk("bp_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    send_byte(wa[31:24], wb[31:24], 1'b0, 1'b1, exp_byte(wa, wb, 3));
    repeat (2) @(posedge clk);
    #1;

    // Abort: two bytes of one word, then a new word with start.
    send_word(32'hFFFFFFFF, 32'h00000001, 2);
    send_word(32'h00000002, 32'h00000003, 4);
    repeat (3) @(posedge clk);
    #1;

    // Async reset mid-word while byte 2 is presented.
    wa = 32'h01020304;
    wb = 32'hF0F0F0F0;
    send_byte(wa[7:0],  wb[7:0],  1'b1, 1'b1, exp_byte(wa, wb, 0));
    send_byte(wa[15:8], wb[15:8], 1'b0, 1'b0, exp_byte(wa, wb, 1));
    bus.a_in     = wa[23:16];
    bus.b_in     = wb[23:16];
    bus.in_valid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_busy",      {31'd0, busy},          32'd0);
    chk("arst_carry_out", {31'd0, bus.carry_out}, 32'd0);
    chk("arst_out_last",  {31'd0, bus.out_last},  32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'h89ABCDEF, 32'h87654321, 4);
    repeat (2) @(posedge clk);
    #1;

    // A byte without start while idle must vanish.
    send_byte(8'h55, 8'hAA, 1'b0, 1'b0, exp_byte(32'd0, 32'd0, 0));
    @(negedge clk);
    chk("idle_drop_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("idle_drop_busy",  {31'd0, busy},          32'd0);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard stop if something wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
